// File: rtl/game_pkg.sv
// Shared definitions for the game controller: state encodings, default
// parameters and the state decode used by the timer reload output.
package game_pkg;

    localparam int SCORE_BITS_DEF  = 8;
    localparam int START_DELAY_DEF = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READY  = 3'd1;
    localparam logic [2:0] ST_PLAY   = 3'd2;
    localparam logic [2:0] ST_PAUSED = 3'd3;
    localparam logic [2:0] ST_OVER   = 3'd4;

    // Timer is held in reload while the game has not started counting down.
    function automatic logic loads_timer(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_READY);
    endfunction

endpackage

// File: rtl/score_counter.sv
// Saturating up/down score register with synchronous clear.
// Simultaneous inc and dec cancel out.
module score_counter
    import game_pkg::*;
#(
    parameter int WIDTH = SCORE_BITS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] VAL_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] VAL_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_value_nxt;

    // Next-value selection with saturation at both ends
    always_comb begin
        w_value_nxt = r_value;
        if (clr) begin
            w_value_nxt = VAL_ZERO;
        end else if (inc && !dec) begin
            if (r_value != VAL_MAX) begin
                w_value_nxt = r_value + VAL_ONE;
            end else begin
                w_value_nxt = r_value;
            end
        end else if (dec && !inc) begin
            if (r_value != VAL_ZERO) begin
                w_value_nxt = r_value - VAL_ONE;
            end else begin
                w_value_nxt = r_value;
            end
        end else begin
            w_value_nxt = r_value;
        end
    end

    // Score storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= VAL_ZERO;
        end else begin
            r_value <= w_value_nxt;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/game_fsm.sv
// Game controller: countdown, play/pause, scoring and high-score tracking.
// Only timer_enable is combinational; everything else is registered.
module game_fsm
    import game_pkg::*;
#(
    parameter int SCORE_BITS  = SCORE_BITS_DEF,
    parameter int START_DELAY = START_DELAY_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sec_tick,
    input  logic                  start_p,
    input  logic                  pause_p,
    input  logic                  hit_p,
    input  logic                  miss_p,
    input  logic                  timer_done,
    output logic                  load_timer,
    output logic                  timer_enable,
    output logic [2:0]            state,
    output logic [2:0]            ready_count,
    output logic [SCORE_BITS-1:0] score,
    output logic [SCORE_BITS-1:0] high_score,
    output logic                  new_high
);

    localparam logic [2:0] RDY_INIT = 3'(START_DELAY);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [2:0]            r_ready_count;
    logic [2:0]            w_ready_nxt;
    logic [SCORE_BITS-1:0] r_high_score;
    logic [SCORE_BITS-1:0] w_high_nxt;
    logic                  r_new_high;
    logic                  w_new_high_nxt;
    logic                  r_load_timer;
    logic                  w_inc;
    logic                  w_dec;
    logic                  w_clr;
    logic [SCORE_BITS-1:0] w_score;

    score_counter #(
        .WIDTH (SCORE_BITS)
    ) u_score (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc),
        .dec   (w_dec),
        .clr   (w_clr),
        .value (w_score)
    );

    // Next-state, countdown, scoring and high-score decisions
    always_comb begin
        w_state_nxt    = r_state;
        w_ready_nxt    = r_ready_count;
        w_high_nxt     = r_high_score;
        w_new_high_nxt = r_new_high;
        w_inc          = 1'b0;
        w_dec          = 1'b0;
        w_clr          = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (start_p) begin
                    w_state_nxt    = ST_READY;
                    w_ready_nxt    = RDY_INIT;
                    w_clr          = 1'b1;
                    w_new_high_nxt = 1'b0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_READY: begin
                if (sec_tick) begin
                    if (r_ready_count <= 3'd1) begin
                        w_state_nxt = ST_PLAY;
                        w_ready_nxt = 3'd0;
                    end else begin
                        w_ready_nxt = r_ready_count - 3'd1;
                    end
                end else begin
                    w_ready_nxt = r_ready_count;
                end
            end
            ST_PLAY: begin
                // Game end outranks pause, which outranks scoring events.
                if (timer_done) begin
                    w_state_nxt = ST_OVER;
                    if (w_score > r_high_score) begin
                        w_high_nxt     = w_score;
                        w_new_high_nxt = 1'b1;
                    end else begin
                        w_high_nxt     = r_high_score;
                        w_new_high_nxt = r_new_high;
                    end
                end else if (pause_p) begin
                    w_state_nxt = ST_PAUSED;
                end else begin
                    w_inc = hit_p & ~miss_p;
                    w_dec = miss_p & ~hit_p;
                end
            end
            ST_PAUSED: begin
                if (pause_p) begin
                    w_state_nxt = ST_PLAY;
                end else begin
                    w_state_nxt = ST_PAUSED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ready_count <= RDY_INIT;
            r_high_score  <= {SCORE_BITS{1'b0}};
            r_new_high    <= 1'b0;
            r_load_timer  <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_ready_count <= w_ready_nxt;
            r_high_score  <= w_high_nxt;
            r_new_high    <= w_new_high_nxt;
            r_load_timer  <= loads_timer(w_state_nxt);
        end
    end

    assign timer_enable = sec_tick & (r_state == ST_PLAY);
    assign load_timer   = r_load_timer;
    assign state        = r_state;
    assign ready_count  = r_ready_count;
    assign score        = w_score;
    assign high_score   = r_high_score;
    assign new_high     = r_new_high;

endmodule

// File: tb/tb_game_fsm.sv
// Scoreboard bench for game_fsm: expectations are queued with each stimulus
// cycle and compared once the DUT has had the corresponding clock edge.
module tb_game_fsm;
    import game_pkg::*;

    localparam int RDY = 3;

    logic clk = 1'b0;
    logic reset, sec_tick, start_p, pause_p, hit_p, miss_p, timer_done;

    logic       load_timer, timer_enable, new_high;
    logic [2:0] state, ready_count;
    logic [7:0] score, high_score;

    logic       load_timer4, timer_enable4, new_high4;
    logic [2:0] state4, ready_count4;
    logic [3:0] score4, high_score4;

    game_fsm #(.SCORE_BITS(8), .START_DELAY(RDY)) dut (
        .clk(clk), .reset(reset), .sec_tick(sec_tick), .start_p(start_p),
        .pause_p(pause_p), .hit_p(hit_p), .miss_p(miss_p), .timer_done(timer_done),
        .load_timer(load_timer), .timer_enable(timer_enable), .state(state),
        .ready_count(ready_count), .score(score), .high_score(high_score),
        .new_high(new_high)
    );

    game_fsm #(.SCORE_BITS(4), .START_DELAY(RDY)) dut4 (
        .clk(clk), .reset(reset), .sec_tick(sec_tick), .start_p(start_p),
        .pause_p(pause_p), .hit_p(hit_p), .miss_p(miss_p), .timer_done(timer_done),
        .load_timer(load_timer4), .timer_enable(timer_enable4), .state(state4),
        .ready_count(ready_count4), .score(score4), .high_score(high_score4),
        .new_high(new_high4)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    id;
        int    val;
    } exp_t;

    exp_t q_post[$];
    exp_t q_comb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sc;
    int   hi;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int id);
        case (id)
            0:       return 32'(state);
            1:       return 32'(ready_count);
            2:       return 32'(score);
            3:       return 32'(high_score);
            4:       return 32'(new_high);
            5:       return 32'(load_timer);
            6:       return 32'(timer_enable);
            7:       return 32'(score4);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push_post(input string tag, input int id, input int val);
        exp_t e;
        e.tag = tag; e.id = id; e.val = val;
        q_post.push_back(e);
    endtask

    task automatic drain_post();
        exp_t e;
        while (q_post.size() > 0) begin
            e = q_post.pop_front();
            check_val(e.tag, observe(e.id), 32'(e.val));
        end
    endtask

    task automatic drain_comb();
        exp_t e;
        while (q_comb.size() > 0) begin
            e = q_comb.pop_front();
            check_val(e.tag, observe(e.id), 32'(e.val));
        end
    endtask

    // Full visible state expected after the next clock edge.
    task automatic exp_st(input string tag, input int st, input int rc, input int s, input int h, input int nh);
        push_post({tag, ".state"}, 0, st);
        push_post({tag, ".ready"}, 1, rc);
        push_post({tag, ".score"}, 2, s);
        push_post({tag, ".high"},  3, h);
        push_post({tag, ".newhi"}, 4, nh);
        push_post({tag, ".load"},  5, (st == 0 || st == 1) ? 1 : 0);
        push_post({tag, ".score4"}, 7, (s > 15) ? 15 : s);
    endtask

    // One stimulus cycle; timer_enable is checked before the edge.
    task automatic drive(input logic t, input logic s, input logic p, input logic h,
                         input logic m, input logic d, input int te);
        exp_t e;
        sec_tick = t; start_p = s; pause_p = p; hit_p = h; miss_p = m; timer_done = d;
        e.tag = "tmr_en"; e.id = 6; e.val = te;
        q_comb.push_back(e);
        #1;
        drain_comb();
        @(posedge clk);
        #1;
        drain_post();
        sec_tick = 1'b0; start_p = 1'b0; pause_p = 1'b0;
        hit_p = 1'b0; miss_p = 1'b0; timer_done = 1'b0;
    endtask

    task automatic run_countdown();
        exp_st("start", 1, RDY, 0, hi, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        sc = 0;
        for (int k = RDY - 1; k >= 1; k--) begin
            exp_st("count", 1, k, 0, hi, 0);
            drive(1, 0, 0, 0, 0, 0, 0);
        end
        exp_st("to_play", 2, 0, 0, hi, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic hits(input int n, input int nh);
        for (int i = 0; i < n; i++) begin
            sc = (sc < 255) ? sc + 1 : 255;
            exp_st("hit", 2, 0, sc, hi, nh);
            drive(1, 0, 0, 1, 0, 0, 1);
        end
    endtask

    initial begin
        reset = 1'b1; sec_tick = 1'b1; start_p = 1'b0; pause_p = 1'b0;
        hit_p = 1'b0; miss_p = 1'b0; timer_done = 1'b0;
        sc = 0; hi = 0;
        #2;
        exp_st("reset", 0, RDY, 0, 0, 0);
        push_post("reset.tmr_en", 6, 0);
        drain_post();
        @(negedge clk);
        reset = 1'b0; sec_tick = 1'b0;

        exp_st("idle_ignore", 0, RDY, 0, 0, 0);
        drive(1, 0, 1, 1, 0, 1, 0);

        // Countdown with an ignored start in READY
        exp_st("start", 1, RDY, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        exp_st("rdy2", 1, 2, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        exp_st("rdy_start_ign", 1, 2, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        exp_st("rdy1", 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        exp_st("play", 2, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);

        // 5 hits, 2 misses, one simultaneous pair
        hits(5, 0);
        for (int i = 0; i < 2; i++) begin
            sc--;
            exp_st("miss", 2, 0, sc, 0, 0);
            drive(0, 0, 0, 0, 1, 0, 0);
        end
        exp_st("hit_miss", 2, 0, 3, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0);
        exp_st("play_start_ign", 2, 0, 3, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);

        // Saturation at zero
        for (int i = 0; i < 4; i++) begin
            sc = (sc > 0) ? sc - 1 : 0;
            exp_st("miss_sat", 2, 0, sc, 0, 0);
            drive(0, 0, 0, 0, 1, 0, 0);
        end

        // Pause with concurrent hit, ignored inputs, resume
        hits(2, 0);
        exp_st("pause", 3, 0, 2, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            exp_st("paused", 3, 0, 2, 0, 0);
            drive(1, (i == 0), 0, (i % 2 == 0), (i % 2 == 1), 0, 0);
        end
        exp_st("resume", 2, 0, 2, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);

        // First game ends at 4
        hits(2, 0);
        hi = 4;
        exp_st("over1", 4, 0, 4, 4, 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        exp_st("over_hold", 4, 0, 4, 4, 1);
        drive(1, 0, 0, 1, 0, 0, 0);

        // Second game: 7 beats 4; hit and pause lose to timer_done
        run_countdown();
        hits(7, 0);
        hi = 7;
        exp_st("over2", 4, 0, 7, 7, 1);
        drive(0, 0, 1, 1, 0, 1, 0);

        // Third game ends at 2: no new high
        run_countdown();
        hits(2, 0);
        exp_st("over3", 4, 0, 2, 7, 0);
        drive(0, 0, 0, 0, 0, 1, 0);

        // Asynchronous reset mid-game
        run_countdown();
        hits(9, 0);
        #2;
        reset = 1'b1;
        #1;
        sc = 0; hi = 0;
        exp_st("async_rst", 0, RDY, 0, 0, 0);
        drain_post();
        @(negedge clk);
        reset = 1'b0;

        // Narrow counter saturates at 15 while the wide one keeps counting
        run_countdown();
        hits(17, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_fsm.md
GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 The block SHALL have parameter SCORE_BITS, default 8, giving the width of the score and high score.
REQ-002 The block SHALL have parameter START_DELAY, default 3, giving the number of sec_tick pulses in the READY countdown (legal range 1-7).
REQ-003 The block SHALL have clk, input, 1, the system clock; all logic is rising-edge.
REQ-004 The block SHALL have reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have sec_tick, input, 1, a one-cycle 1 Hz enable pulse from the tick generator.
REQ-006 The block SHALL have start_p, input, 1, a one-cycle debounced start-button pulse.
REQ-007 The block SHALL have pause_p, input, 1, a one-cycle debounced pause-button pulse.
REQ-008 The block SHALL have hit_p and miss_p, input, 1 each, one-cycle scoring event pulses.
REQ-009 The block SHALL have timer_done, input, 1, the zero flag from the game timer.
REQ-010 The block SHALL have load_timer, output, 1, the reload request to the game timer.
REQ-011 The block SHALL have timer_enable, output, 1, the gated second tick to the game timer.
REQ-012 The block SHALL have state, output, 3, the current FSM state encoding.
REQ-013 The block SHALL have ready_count, output, 3, the seconds remaining in READY.
REQ-014 The block SHALL have score and high_score, output, SCORE_BITS each.
REQ-015 The block SHALL have new_high, output, 1, set when the last game beat the stored high score.

Function
REQ-016 The FSM SHALL have states IDLE=0, READY=1, PLAY=2, PAUSED=3, OVER=4, and all other encodings SHALL return to IDLE on the next clock.
REQ-017 load_timer SHALL be a Moore output, high in IDLE and READY and low otherwise.
REQ-018 timer_enable SHALL be combinational: sec_tick AND (state==PLAY), with zero added latency.
REQ-019 IDLE or OVER with start_p SHALL go to READY, clear score and new_high, and load ready_count with START_DELAY, all on the same edge.
REQ-020 In READY, each sec_tick SHALL decrement ready_count; a sec_tick with ready_count==1 SHALL go to PLAY and leave ready_count at 0.
REQ-021 In PLAY, event priority SHALL be: timer_done, then pause_p, then hit_p/miss_p.
REQ-022 PLAY with timer_done high SHALL go to OVER, and hit_p/miss_p in that cycle SHALL be discarded.
REQ-023 PLAY with pause_p (and timer_done low) SHALL go to PAUSED, and the score SHALL be unchanged that cycle.
REQ-024 In PLAY, hit_p alone SHALL increment score, saturating at 2^SCORE_BITS-1.
REQ-025 In PLAY, miss_p alone SHALL decrement score, saturating at 0.
REQ-026 In PLAY, hit_p and miss_p together SHALL leave score unchanged.
REQ-027 In PAUSED, pause_p SHALL return to PLAY; hit_p, miss_p, start_p and sec_tick SHALL be ignored.
REQ-028 On the PLAY->OVER edge, if score > high_score, high_score SHALL load score and new_high SHALL set; otherwise both SHALL hold.
REQ-029 start_p SHALL be ignored in READY, PLAY and PAUSED.
REQ-030 score and high_score SHALL hold in every state except as stated above.

Reset
REQ-031 Reset SHALL force state=IDLE, score=0, high_score=0, new_high=0 and ready_count=START_DELAY.
REQ-032 During and after reset, load_timer=1 and timer_enable=0.
REQ-033 Reset asserted mid-game SHALL abandon the game with no high-score update.

Structure
REQ-034 State encodings and default SCORE_BITS/START_DELAY SHALL live in shared package game_pkg.
REQ-035 The saturating up/down score register SHALL be a sub-module named score_counter (inputs inc, dec, clr; output value).
REQ-036 All registers SHALL be in the clk domain; outputs other than timer_enable SHALL be register- or state-decoded.

Verification
REQ-037 Reset, start_p, then 3 sec_ticks -> ready_count 3,2,1,0; PLAY on the 3rd tick; load_timer drops the same cycle.
REQ-038 In PLAY: 5 hit_p, 2 miss_p, then 1 cycle with hit_p and miss_p together -> score=3.
REQ-039 score=0, miss_p -> score=0; SCORE_BITS=4, 16 hit_p -> score=15.
REQ-040 pause_p in PLAY, 4 sec_ticks, then pause_p -> timer_enable stays 0 while paused; PLAY resumes with score intact.
REQ-041 score=7, high_score=4, timer_done with hit_p in the same cycle -> OVER, high_score=7, new_high=1; next game ends at 2 -> high_score=7, new_high=0.
REQ-042 Reset asserted in PLAY with score=9 -> IDLE, score=0, high_score=0 immediately (asynchronous).
